// File: rtl/vga_timing_generator_if.sv
// Pixel-side signal bundle of the VGA timing generator.
// Master is the generator; slave is the frame source / pin driver.
interface vga_timing_generator_if #(
    parameter int X_WIDTH = 10,
    parameter int Y_WIDTH = 10
);
    logic               pixelEnable;
    logic [X_WIDTH-1:0] x;
    logic [Y_WIDTH-1:0] y;
    logic               lineStart;
    logic               frameStart;
    logic               vBlankStart;
    logic               hSync;
    logic               vSync;
    logic               isActive;

    modport master (
        input  pixelEnable,
        output x,
        output y,
        output lineStart,
        output frameStart,
        output vBlankStart,
        output hSync,
        output vSync,
        output isActive
    );

    modport slave (
        output pixelEnable,
        input  x,
        input  y,
        input  lineStart,
        input  frameStart,
        input  vBlankStart,
        input  hSync,
        input  vSync,
        input  isActive
    );
endinterface

// File: rtl/vga_timing_generator.sv
// Parametrised VGA timing generator: h/v counters, undelayed coordinates
// and strobes, plus a delay line that keeps syncs aligned to pixel data.
module vga_timing_generator #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FPORCH   = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BPORCH   = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FPORCH   = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BPORCH   = 33,
    parameter int H_SYNC_POL = 0,
    parameter int V_SYNC_POL = 0,
    parameter int PIPE_DELAY = 2,
    parameter int X_WIDTH    = 10,
    parameter int Y_WIDTH    = 10
) (
    input  logic                   clock,
    input  logic                   resetN,
    vga_timing_generator_if.master vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FPORCH + H_SYNC + H_BPORCH;
    localparam int V_TOTAL = V_ACTIVE + V_FPORCH + V_SYNC + V_BPORCH;
    localparam int DEPTH   = PIPE_DELAY + 1;

    localparam logic [X_WIDTH-1:0] H_LAST  = X_WIDTH'(H_TOTAL - 1);
    localparam logic [X_WIDTH-1:0] H_VIS   = X_WIDTH'(H_ACTIVE);
    localparam logic [X_WIDTH-1:0] H_SS    = X_WIDTH'(H_ACTIVE + H_FPORCH);
    localparam logic [X_WIDTH-1:0] H_SE    = X_WIDTH'(H_ACTIVE + H_FPORCH + H_SYNC);
    localparam logic [Y_WIDTH-1:0] V_LAST  = Y_WIDTH'(V_TOTAL - 1);
    localparam logic [Y_WIDTH-1:0] V_VIS   = Y_WIDTH'(V_ACTIVE);
    localparam logic [Y_WIDTH-1:0] V_SS    = Y_WIDTH'(V_ACTIVE + V_FPORCH);
    localparam logic [Y_WIDTH-1:0] V_SE    = Y_WIDTH'(V_ACTIVE + V_FPORCH + V_SYNC);

    localparam logic H_ON = (H_SYNC_POL != 0);
    localparam logic V_ON = (V_SYNC_POL != 0);

    // Idle stage contents: both syncs deasserted, video inactive.
    localparam logic [2:0] IDLE = {~H_ON, ~V_ON, 1'b0};

    logic [X_WIDTH-1:0] h_count;
    logic [Y_WIDTH-1:0] v_count;
    logic               h_wrap;
    logic               v_wrap;
    logic               raw_active;
    logic               raw_hsync;
    logic               raw_vsync;
    logic               tick;
    logic [2:0]         pipe [DEPTH];

    assign h_wrap = (h_count == H_LAST);
    assign v_wrap = (v_count == V_LAST);

    // Pixel and line counters; the line counter steps on the pixel wrap.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            h_count <= '0;
            v_count <= '0;
        end else if (vga.pixelEnable) begin
            h_count <= h_wrap ? '0 : h_count + 1'b1;
            if (h_wrap) begin
                v_count <= v_wrap ? '0 : v_count + 1'b1;
            end
        end
    end

    // Raw timing decoded straight from the counters.
    always_comb begin
        raw_active = (h_count < H_VIS) && (v_count < V_VIS);
        raw_hsync  = ((h_count >= H_SS) && (h_count < H_SE)) ? H_ON : ~H_ON;
        raw_vsync  = ((v_count >= V_SS) && (v_count < V_SE)) ? V_ON : ~V_ON;
    end

    // Delay line: stage 0 samples raw timing, later stages shift it along.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe[i] <= IDLE;
            end
        end else if (vga.pixelEnable) begin
            pipe[0] <= {raw_hsync, raw_vsync, raw_active};
            for (int i = 1; i < DEPTH; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    // Strobes are suppressed while reset is held, even though counters sit at 0.
    assign tick            = vga.pixelEnable && resetN;
    assign vga.lineStart   = tick && (h_count == '0);
    assign vga.frameStart  = vga.lineStart && (v_count == '0);
    assign vga.vBlankStart = vga.lineStart && (v_count == V_VIS);

    assign vga.x = raw_active ? h_count : '0;
    assign vga.y = raw_active ? v_count : '0;

    assign vga.hSync    = pipe[DEPTH-1][2];
    assign vga.vSync    = pipe[DEPTH-1][1];
    assign vga.isActive = pipe[DEPTH-1][0];
endmodule

// File: tb/tb_vga_timing_generator.sv
// Directed bench for vga_timing_generator: default 640x480 mode,
// an 8x6 small mode (PIPE_DELAY 0) and the same small mode with PIPE_DELAY 15.
module tb_vga_timing_generator;
    logic clock = 1'b0;
    logic resetN;
    logic pixelEnable;
    int   n;
    int   checks;
    int   fails;

    always #5 clock = ~clock;

    vga_timing_generator_if #(.X_WIDTH(10), .Y_WIDTH(10)) def_if ();
    vga_timing_generator_if #(.X_WIDTH(10), .Y_WIDTH(10)) sm_if ();
    vga_timing_generator_if #(.X_WIDTH(10), .Y_WIDTH(10)) dp_if ();

    assign def_if.pixelEnable = pixelEnable;
    assign sm_if.pixelEnable  = pixelEnable;
    assign dp_if.pixelEnable  = pixelEnable;

    vga_timing_generator u_def (
        .clock  (clock),
        .resetN (resetN),
        .vga    (def_if.master)
    );

    vga_timing_generator #(
        .H_ACTIVE(4), .H_FPORCH(1), .H_SYNC(2), .H_BPORCH(1),
        .V_ACTIVE(3), .V_FPORCH(1), .V_SYNC(1), .V_BPORCH(1),
        .H_SYNC_POL(1), .V_SYNC_POL(1), .PIPE_DELAY(0)
    ) u_sm (
        .clock  (clock),
        .resetN (resetN),
        .vga    (sm_if.master)
    );

    vga_timing_generator #(
        .H_ACTIVE(4), .H_FPORCH(1), .H_SYNC(2), .H_BPORCH(1),
        .V_ACTIVE(3), .V_FPORCH(1), .V_SYNC(1), .V_BPORCH(1),
        .H_SYNC_POL(0), .V_SYNC_POL(0), .PIPE_DELAY(15)
    ) u_dp (
        .clock  (clock),
        .resetN (resetN),
        .vga    (dp_if.master)
    );

    wire [25:0] def_b = {def_if.x, def_if.y, def_if.lineStart, def_if.frameStart,
                         def_if.vBlankStart, def_if.hSync, def_if.vSync, def_if.isActive};
    wire [25:0] sm_b  = {sm_if.x, sm_if.y, sm_if.lineStart, sm_if.frameStart,
                         sm_if.vBlankStart, sm_if.hSync, sm_if.vSync, sm_if.isActive};
    wire [25:0] dp_b  = {dp_if.x, dp_if.y, dp_if.lineStart, dp_if.frameStart,
                         dp_if.vBlankStart, dp_if.hSync, dp_if.vSync, dp_if.isActive};

    // Small mode: H_TOTAL 8 (active 0..3, sync 5..6), V_TOTAL 6 (active 0..2, sync 4).
    function automatic int sh(int k);
        return k % 8;
    endfunction

    function automatic int sv(int k);
        return (k / 8) % 6;
    endfunction

    function automatic bit s_act(int k);
        return (k >= 0) && (sh(k) < 4) && (sv(k) < 3);
    endfunction

    function automatic bit s_hs(int k);
        return (k >= 0) && (sh(k) >= 5) && (sh(k) <= 6);
    endfunction

    function automatic bit s_vs(int k);
        return (k >= 0) && (sv(k) == 4);
    endfunction

    // Expected small-mode bundle after k enabled ticks, with a lag of "lag" on the delayed flags.
    function automatic logic [25:0] sm_exp(int k, int lag, bit pol, bit en);
        logic [9:0] ex;
        logic [9:0] ey;
        bit ls, fs, vb, hs, vs;
        ex = s_act(k) ? 10'(sh(k)) : 10'd0;
        ey = s_act(k) ? 10'(sv(k)) : 10'd0;
        ls = en && (sh(k) == 0);
        fs = ls && (sv(k) == 0);
        vb = ls && (sv(k) == 3);
        hs = s_hs(k - lag) ? pol : !pol;
        vs = s_vs(k - lag) ? pol : !pol;
        return {ex, ey, ls, fs, vb, hs, vs, s_act(k - lag)};
    endfunction

    task automatic tick();
        @(posedge clock);
        if (pixelEnable) n++;
        #1;
    endtask

    task automatic test_reset();
        resetN = 1'b1;
        pixelEnable = 1'b1;
        #2 resetN = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (def_b !== {20'd0, 3'b000, 3'b110}) begin
            fails++;
            $display("FAIL reset_def got %h want %h", def_b, {20'd0, 3'b000, 3'b110});
        end
        checks++;
        if (sm_b !== 26'd0) begin
            fails++;
            $display("FAIL reset_sm got %h want %h", sm_b, 26'd0);
        end
        checks++;
        if (dp_b !== {20'd0, 3'b000, 3'b110}) begin
            fails++;
            $display("FAIL reset_dp got %h want %h", dp_b, {20'd0, 3'b000, 3'b110});
        end
        @(negedge clock);
        resetN = 1'b1;
        n = 0;
        #1;
        checks++;
        if ({def_if.frameStart, sm_if.frameStart, dp_if.frameStart} !== 3'b111) begin
            fails++;
            $display("FAIL release_frameStart got %b want 111",
                     {def_if.frameStart, sm_if.frameStart, dp_if.frameStart});
        end
        checks++;
        if (sm_b !== sm_exp(0, 1, 1'b1, 1'b1)) begin
            fails++;
            $display("FAIL release_sm got %h want %h", sm_b, sm_exp(0, 1, 1'b1, 1'b1));
        end
    endtask

    task automatic test_pipe_delay();
        for (int i = 0; i < 48; i++) begin
            tick();
            checks++;
            if (dp_b !== sm_exp(n, 16, 1'b0, 1'b1)) begin
                fails++;
                $display("FAIL pipe15 n=%0d got %h want %h", n, dp_b, sm_exp(n, 16, 1'b0, 1'b1));
            end
        end
    endtask

    task automatic test_small_mode();
        logic [9:0] xseq [8];
        int fs_cnt, vb_cnt;
        xseq = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd0, 10'd0, 10'd0, 10'd0};
        fs_cnt = 0;
        vb_cnt = 0;
        for (int i = 0; i < 48; i++) begin
            tick();
            if (sm_if.frameStart === 1'b1) fs_cnt++;
            if (sm_if.vBlankStart === 1'b1) vb_cnt++;
            checks++;
            if (sm_b !== sm_exp(n, 1, 1'b1, 1'b1)) begin
                fails++;
                $display("FAIL small n=%0d got %h want %h", n, sm_b, sm_exp(n, 1, 1'b1, 1'b1));
            end
            if (sv(n) < 3) begin
                checks++;
                if (sm_if.x !== xseq[sh(n)]) begin
                    fails++;
                    $display("FAIL small_x n=%0d got %0d want %0d", n, sm_if.x, xseq[sh(n)]);
                end
            end
        end
        checks++;
        if (fs_cnt != 1 || vb_cnt != 1) begin
            fails++;
            $display("FAIL small_strobe_count got fs=%0d vb=%0d want 1 1", fs_cnt, vb_cnt);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 48; i++) begin
            if (n % 48 == 47) break;
            tick();
        end
        checks++;
        if (sm_b !== sm_exp(47, 1, 1'b1, 1'b1)) begin
            fails++;
            $display("FAIL wrap_pre got %h want %h", sm_b, sm_exp(47, 1, 1'b1, 1'b1));
        end
        tick();
        checks++;
        if ({sm_if.x, sm_if.y, sm_if.frameStart, sm_if.lineStart} !== {20'd0, 2'b11}) begin
            fails++;
            $display("FAIL wrap got x=%0d y=%0d fs=%b ls=%b want 0 0 1 1",
                     sm_if.x, sm_if.y, sm_if.frameStart, sm_if.lineStart);
        end
    endtask

    task automatic test_default_line();
        bit found, prev;
        int fall, low, act, vlow;
        found = 0;
        for (int i = 0; i < 1000; i++) begin
            if (def_if.lineStart === 1'b1) begin
                found = 1;
                break;
            end
            tick();
        end
        checks++;
        if (!found) begin
            fails++;
            $display("FAIL def_lineStart got none want one within 1000 ticks");
        end
        prev = def_if.hSync;
        fall = -1;
        low  = 0;
        act  = 0;
        vlow = 0;
        for (int k = 1; k <= 800; k++) begin
            tick();
            if (prev && !def_if.hSync && fall < 0) fall = k;
            if (!def_if.hSync) low++;
            if (def_if.isActive) act++;
            if (!def_if.vSync) vlow++;
            prev = def_if.hSync;
            if (k == 100) begin
                checks++;
                if (def_if.x !== 10'd100) begin
                    fails++;
                    $display("FAIL def_x got %0d want 100", def_if.x);
                end
            end
        end
        checks++;
        if (fall != 659) begin
            fails++;
            $display("FAIL def_hsync_fall got %0d want 659", fall);
        end
        checks++;
        if (low != 96) begin
            fails++;
            $display("FAIL def_hsync_low got %0d want 96", low);
        end
        checks++;
        if (act != 640) begin
            fails++;
            $display("FAIL def_active got %0d want 640", act);
        end
        checks++;
        if (vlow != 0) begin
            fails++;
            $display("FAIL def_vsync_low got %0d want 0", vlow);
        end
    endtask

    task automatic test_enable_toggle();
        int fs_cnt;
        fs_cnt = 0;
        for (int i = 0; i < 96; i++) begin
            pixelEnable = (i % 2 == 0);
            #1;
            if (sm_if.frameStart === 1'b1) fs_cnt++;
            checks++;
            if (sm_b !== sm_exp(n, 1, 1'b1, pixelEnable)) begin
                fails++;
                $display("FAIL toggle i=%0d got %h want %h", i, sm_b, sm_exp(n, 1, 1'b1, pixelEnable));
            end
            tick();
        end
        pixelEnable = 1'b1;
        checks++;
        if (fs_cnt != 1) begin
            fails++;
            $display("FAIL toggle_frames got %0d want 1", fs_cnt);
        end
    endtask

    task automatic test_reset_mid_sync();
        for (int i = 0; i < 48; i++) begin
            if (sh(n) == 6 && sv(n) == 2) break;
            tick();
        end
        checks++;
        if (sm_if.hSync !== 1'b1) begin
            fails++;
            $display("FAIL midsync_pre got %b want 1", sm_if.hSync);
        end
        #2 resetN = 1'b0;
        #1;
        checks++;
        if (sm_b !== 26'd0) begin
            fails++;
            $display("FAIL midsync_sm got %h want %h", sm_b, 26'd0);
        end
        checks++;
        if (def_b !== {20'd0, 3'b000, 3'b110}) begin
            fails++;
            $display("FAIL midsync_def got %h want %h", def_b, {20'd0, 3'b000, 3'b110});
        end
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if ({sm_b, dp_b[8:0]} !== {26'd0, 9'b000_000_110}) begin
            fails++;
            $display("FAIL midsync_hold got %h %h", sm_b, dp_b);
        end
        @(negedge clock);
        resetN = 1'b1;
        n = 0;
        #1;
        checks++;
        if ({sm_if.frameStart, sm_if.isActive, def_if.frameStart} !== 3'b101) begin
            fails++;
            $display("FAIL midsync_release got %b want 101",
                     {sm_if.frameStart, sm_if.isActive, def_if.frameStart});
        end
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if ({sm_if.isActive, def_if.isActive} !== {1'b1, (k == 3)}) begin
                fails++;
                $display("FAIL midsync_active k=%0d got %b want %b",
                         k, {sm_if.isActive, def_if.isActive}, {1'b1, (k == 3)});
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        fails  = 0;
        n      = 0;
        test_reset();
        test_pipe_delay();
        test_small_mode();
        test_wrap();
        test_default_line();
        test_enable_toggle();
        test_reset_mid_sync();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
